// File: rtl/serial_a_tx.sv
// Strobed serial transmitter: start bit, LSB-first payload, optional even
// parity, stop bit. The line advances one bit per clock that has enable=1.
module serial_a_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  a,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_parity;
  logic                  r_a;
  logic                  r_done;

  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_parity_nxt;
  logic                  w_a_nxt;
  logic                  w_done_nxt;

  // Parity is captured at the handshake because the shift register is
  // consumed while the payload goes out.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_cnt_nxt    = r_cnt;
    w_parity_nxt = r_parity;
    w_a_nxt      = r_a;
    w_done_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_a_nxt = 1'b1;
        if (valid_in) begin
          w_shift_nxt  = data_in;
          w_parity_nxt = ^data_in;
          w_a_nxt      = 1'b0;
          w_state_nxt  = START;
        end
      end
      START: begin
        w_a_nxt = 1'b0;
        if (enable) begin
          w_a_nxt     = r_shift[0];
          w_cnt_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (enable) begin
          if (r_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              w_a_nxt     = r_parity;
              w_state_nxt = PARITY;
            end else begin
              w_a_nxt     = 1'b1;
              w_state_nxt = STOP;
            end
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_a_nxt     = r_shift[1];
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (enable) begin
          w_a_nxt     = 1'b1;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        w_a_nxt = 1'b1;
        if (enable) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_a_nxt     = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_parity <= 1'b0;
      r_a      <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_cnt    <= w_cnt_nxt;
      r_parity <= w_parity_nxt;
      r_a      <= w_a_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign ready_out = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign a         = r_a;
  assign done      = r_done;

endmodule
